// File: rtl/matmul_alu_sequencer_pkg.sv
// Shared types and constants for the matrix-multiply issue stage.
package mm_pkg;

    localparam int DATA_W = 32;
    // Index registers cover DIM up to 8 (indices 0..7).
    localparam int IDX_W  = 3;

    localparam logic [3:0] ALU_MUL = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MUL   = 3'd2,
        S_ACC   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/matmul_alu_sequencer_if.sv
// Operand memory and ALU bus between the sequencer (master) and the
// memory/ALU side (slave).
interface matmul_alu_sequencer_if #(
    parameter int ADDR_W = 8
);
    import mm_pkg::*;

    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_rdata;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_rdata;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] alu_data1;
    logic [DATA_W-1:0] alu_data2;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_out;

    modport master (
        output a_addr, b_addr, c_we, c_addr, c_wdata,
               alu_data1, alu_data2, alu_ctrl,
        input  a_rdata, b_rdata, alu_out
    );

    modport slave (
        input  a_addr, b_addr, c_we, c_addr, c_wdata,
               alu_data1, alu_data2, alu_ctrl,
        output a_rdata, b_rdata, alu_out
    );

endinterface

// File: rtl/matmul_alu_sequencer_index.sv
// Nested i/j/k index counter: k steps per accumulate, j/i step per
// finished C element, with last-index flags for the sequencer FSM.
module mm_index_counter
    import mm_pkg::*;
#(
    parameter int DIM = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             k_inc,
    input  logic             elem_adv,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic [IDX_W-1:0] k,
    output logic             i_last,
    output logic             j_last,
    output logic             k_last
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    assign i_last = (i == LAST);
    assign j_last = (j == LAST);
    assign k_last = (k == LAST);

    // Index update: k advances inside a dot product, j/i advance per element.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (k_inc) begin
            k <= k + 1'b1;
        end else if (elem_adv) begin
            k <= '0;
            if (j_last) begin
                j <= '0;
                i <= i_last ? '0 : i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_alu_sequencer.sv
// Issue stage for the execute ALU: computes C = A x B by walking i/j/k,
// issuing a multiply then an accumulate per k, and writing each C element.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs at rest values
// S_READ  | present A[i][k] and B[k][j] addresses to operand memory
// S_MUL   | ALU multiplies the returned operands; capture into prod
// S_ACC   | ALU adds prod to running sum (0 when k==0); capture into acc
// S_WRITE | write acc to C[i][j], advance j/i
// S_DONE  | one-cycle done pulse
module matmul_alu_sequencer
    import mm_pkg::*;
#(
    parameter int DIM    = 2,
    parameter int ADDR_W = 8,
    parameter int A_BASE = 0,
    parameter int B_BASE = 64,
    parameter int C_BASE = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    matmul_alu_sequencer_if.master bus
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] acc;
    logic [IDX_W-1:0]  i;
    logic [IDX_W-1:0]  j;
    logic [IDX_W-1:0]  k;
    logic              i_last;
    logic              j_last;
    logic              k_last;
    logic              run_start;
    logic [ADDR_W-1:0] a_lin;
    logic [ADDR_W-1:0] b_lin;
    logic [ADDR_W-1:0] c_lin;

    assign run_start = (state == S_IDLE) && start;

    // Row-major addressing, computed directly at ADDR_W so it wraps there.
    assign a_lin = ADDR_W'(A_BASE) + ADDR_W'(i) * ADDR_W'(DIM) + ADDR_W'(k);
    assign b_lin = ADDR_W'(B_BASE) + ADDR_W'(k) * ADDR_W'(DIM) + ADDR_W'(j);
    assign c_lin = ADDR_W'(C_BASE) + ADDR_W'(i) * ADDR_W'(DIM) + ADDR_W'(j);

    mm_index_counter #(
        .DIM (DIM)
    ) u_index (
        .clk      (clk),
        .rst      (rst),
        .clear    (run_start),
        .k_inc    ((state == S_ACC) && !k_last),
        .elem_adv (state == S_WRITE),
        .i        (i),
        .j        (j),
        .k        (k),
        .i_last   (i_last),
        .j_last   (j_last),
        .k_last   (k_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Product and running-sum capture from the ALU result.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (state == S_MUL) begin
                prod <= bus.alu_out;
            end
            if (run_start) begin
                acc <= '0;
            end else if (state == S_ACC) begin
                acc <= bus.alu_out;
            end
        end
    end

    // Next state and outputs; reset forces rest values in the same cycle so
    // a reset landing on WRITE never produces a write.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        bus.a_addr    = '0;
        bus.b_addr    = '0;
        bus.c_we      = 1'b0;
        bus.c_addr    = '0;
        bus.c_wdata   = '0;
        bus.alu_data1 = '0;
        bus.alu_data2 = '0;
        bus.alu_ctrl  = ALU_ADD;
        if (!rst) begin
            busy = (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_READ;
                    end
                end
                S_READ: begin
                    bus.a_addr = a_lin;
                    bus.b_addr = b_lin;
                    state_nxt  = S_MUL;
                end
                S_MUL: begin
                    bus.alu_data1 = bus.a_rdata;
                    bus.alu_data2 = bus.b_rdata;
                    bus.alu_ctrl  = ALU_MUL;
                    state_nxt     = S_ACC;
                end
                S_ACC: begin
                    bus.alu_data1 = (k == '0) ? '0 : acc;
                    bus.alu_data2 = prod;
                    bus.alu_ctrl  = ALU_ADD;
                    state_nxt     = k_last ? S_WRITE : S_READ;
                end
                S_WRITE: begin
                    bus.c_we    = 1'b1;
                    bus.c_addr  = c_lin;
                    bus.c_wdata = acc;
                    state_nxt   = (i_last && j_last) ? S_DONE : S_READ;
                end
                S_DONE: begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule
